// File: rtl/dpram_wpack.sv
// Fill stage for the 128x32 byte-enabled tile buffer: packs an int8 valid/ready
// stream little-endian into 32-bit words and writes them through port A.
module dpram_wpack #(
   parameter int AW = 7,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [LW-1:0] len_words,
   input  logic [7:0]    s_data,
   input  logic          s_valid,
   input  logic          s_last,
   output logic          s_ready,
   output logic [3:0]    wea,
   output logic [AW-1:0] addra,
   output logic [31:0]   dina,
   output logic          busy,
   output logic          done,
   output logic          short
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   base_q;
   logic [LW-1:0]   len_q;
   logic [LW-1:0]   wcnt;
   logic [1:0]      lane;
   logic [3:0][7:0] pack;
   logic            acc, commit, cnt_hit, job_end;

   function automatic logic [3:0] lane_mask(input logic [1:0] l);
      logic [3:0] m;
      case (l)
         2'd0:    m = 4'b0001;
         2'd1:    m = 4'b0011;
         2'd2:    m = 4'b0111;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Lanes below l come from the packing register, lane l is the byte being
   // accepted now, lanes above stay zero so stale bytes never leak out.
   function automatic logic [31:0] pack_word(input logic [3:0][7:0] p,
                                             input logic [7:0] b,
                                             input logic [1:0] l);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(l))
            w[8*k +: 8] = p[k];
         else if (k == int'(l))
            w[8*k +: 8] = b;
      end
      return w;
   endfunction

   assign acc     = s_valid & s_ready;
   assign cnt_hit = (wcnt + LW'(1)) == len_q;
   assign commit  = acc & ((lane == 2'd3) | s_last);
   assign job_end = commit & (s_last | cnt_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (len_words == '0) ? DONE : FILL;
         FILL: if (job_end) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         FILL: begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Accept stage: byte lands in its lane; a completed word is presented next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q <= '0;
         len_q  <= '0;
         wcnt   <= '0;
         lane   <= '0;
         pack   <= '0;
         short  <= 1'b0;
         wea    <= '0;
         addra  <= '0;
         dina   <= '0;
      end else begin
         wea <= '0;
         if (state == IDLE && start) begin
            base_q <= base_addr;
            len_q  <= len_words;
            wcnt   <= '0;
            lane   <= '0;
            short  <= 1'b0;
         end else if (acc) begin
            pack[lane] <= s_data;
            if (commit) begin
               wea   <= lane_mask(lane);
               dina  <= pack_word(pack, s_data, lane);
               addra <= base_q + wcnt[AW-1:0];
               lane  <= '0;
               wcnt  <= wcnt + LW'(1);
               if (job_end)
                  short <= s_last & ~cnt_hit;
            end else begin
               lane <= lane + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dpram_wpack.sv
// Directed bench for dpram_wpack: expected port A writes are queued as stimulus
// is driven and popped by a write monitor; control outputs checked inline.
module tb_dpram_wpack;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [6:0] base_addr = '0;
   logic [7:0] len_words = '0;
   logic [7:0] s_data = '0;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic [3:0] wea;
   logic [6:0] addra;
   logic [31:0] dina;
   logic       busy, done, short;

   typedef struct packed {
      logic [6:0]  addr;
      logic [3:0]  we;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_total = 0;
   int  n_pass  = 0;
   int  n_acc   = 0;

   dpram_wpack #(.AW(7), .LW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .len_words(len_words), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready), .wea(wea), .addra(addra),
      .dina(dina), .busy(busy), .done(done), .short(short)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic void push_wr(input logic [6:0] a, input logic [3:0] w, input logic [31:0] d);
      wr_t e;
      e.addr = a; e.we = w; e.data = d;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (s_valid && s_ready) n_acc++;
      if (wea != 4'd0) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", 64'(wea), 64'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 64'(addra), 64'(e.addr));
            chk("wr_wea",  64'(wea),   64'(e.we));
            chk("wr_data", 64'(dina),  64'(e.data));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the byte was taken.
   task automatic send(input logic [7:0] d, input logic last, input int gap);
      bit ok;
      repeat (gap) begin @(posedge clk); #1; end
      s_data = d; s_valid = 1'b1; s_last = last;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk); #1;
      end
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic do_start(input logic [6:0] b, input logic [7:0] l);
      start = 1'b1; base_addr = b; len_words = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic next_cycle;
      @(posedge clk); #1;
   endtask

   initial begin
      int a0;
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
      a0 = 0;
   end

   initial begin
      int a0;
      logic [31:0] w;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_wea",     64'(wea),     64'd0);
      chk("rst_busy",    64'(busy),    64'd0);
      chk("rst_done",    64'(done),    64'd0);
      chk("rst_short",   64'(short),   64'd0);
      chk("rst_addra",   64'(addra),   64'd0);
      rst = 1'b0;
      next_cycle();
      s_valid = 1'b1; s_data = 8'hEE;
      @(negedge clk);
      chk("idle_no_ready", 64'(s_ready), 64'd0);
      next_cycle();
      s_valid = 1'b0;

      // basic fill
      a0 = n_acc;
      do_start(7'd0, 8'd2);
      chk("basic_busy", 64'(busy), 64'd1);
      push_wr(7'd0, 4'hF, 32'h04030201);
      push_wr(7'd1, 4'hF, 32'h08070605);
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 0);
      chk("basic_done",  64'(done),    64'd1);
      chk("basic_short", 64'(short),   64'd0);
      chk("basic_ready", 64'(s_ready), 64'd0);
      chk("basic_busy_last", 64'(busy), 64'd1);
      next_cycle();
      chk("basic_busy_fall", 64'(busy), 64'd0);
      chk("basic_done_fall", 64'(done), 64'd0);
      chk("basic_acc", 64'(n_acc - a0), 64'd8);

      // short stream
      do_start(7'd0, 8'd4);
      push_wr(7'd0, 4'hF, 32'hA3A2A1A0);
      push_wr(7'd1, 4'b0011, 32'h0000A5A4);
      for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i == 5, 0);
      chk("short_done",  64'(done),  64'd1);
      chk("short_short", 64'(short), 64'd1);
      next_cycle();
      chk("short_held", 64'(short), 64'd1);

      // wrap with random backpressure
      do_start(7'd126, 8'd3);
      chk("wrap_short_clr", 64'(short), 64'd0);
      for (int k = 0; k < 3; k++) begin
         w = '0;
         for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'h10 + 8'(4*k + j);
         push_wr(7'(126 + k), 4'hF, w);
      end
      for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), 1'b0, int'($urandom_range(0, 2)));
      chk("wrap_done",  64'(done),  64'd1);
      chk("wrap_short", 64'(short), 64'd0);
      a0 = n_acc;
      s_valid = 1'b1; s_data = 8'h99;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wrap_extra_ready", 64'(s_ready), 64'd0);
         next_cycle();
      end
      s_valid = 1'b0;
      chk("wrap_extra_acc", 64'(n_acc - a0), 64'd0);

      // zero length
      do_start(7'd50, 8'd0);
      chk("zero_done",  64'(done),    64'd1);
      chk("zero_busy",  64'(busy),    64'd1);
      chk("zero_ready", 64'(s_ready), 64'd0);
      next_cycle();
      chk("zero_done_fall", 64'(done), 64'd0);
      chk("zero_busy_fall", 64'(busy), 64'd0);

      // start pulse while busy is ignored
      do_start(7'd20, 8'd2);
      push_wr(7'd20, 4'hF, 32'h33221100);
      push_wr(7'd21, 4'hF, 32'h77665544);
      send(8'h00, 1'b0, 0);
      send(8'h11, 1'b0, 0);
      do_start(7'd99, 8'd1);
      for (int i = 2; i < 8; i++) send(8'(8'h11 * i), 1'b0, 0);
      chk("ign_done", 64'(done), 64'd1);
      next_cycle();

      // reset mid-job discards the partial word
      do_start(7'd5, 8'd2);
      push_wr(7'd5, 4'hF, 32'hB3B2B1B0);
      for (int i = 0; i < 6; i++) send(8'hB0 + 8'(i), 1'b0, 0);
      rst = 1'b1;
      #1;
      chk("mrst_wea",   64'(wea),     64'd0);
      chk("mrst_busy",  64'(busy),    64'd0);
      chk("mrst_done",  64'(done),    64'd0);
      chk("mrst_ready", 64'(s_ready), 64'd0);
      chk("mrst_addra", 64'(addra),   64'd0);
      next_cycle();
      rst = 1'b0;
      next_cycle();
      do_start(7'd30, 8'd1);
      push_wr(7'd30, 4'hF, 32'hC3C2C1C0);
      for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0, 0);
      chk("mrst_new_done", 64'(done), 64'd1);
      next_cycle();

      // back-to-back jobs; s_last on the len-th word is not short
      do_start(7'd0, 8'd1);
      push_wr(7'd0, 4'b0011, 32'h00002211);
      send(8'h11, 1'b0, 0);
      send(8'h22, 1'b1, 0);
      chk("b2b_done1",  64'(done),  64'd1);
      chk("b2b_short1", 64'(short), 64'd0);
      next_cycle();
      chk("b2b_idle", 64'(busy), 64'd0);
      do_start(7'd64, 8'd1);
      chk("b2b_busy2", 64'(busy), 64'd1);
      push_wr(7'd64, 4'b0001, 32'h00000055);
      send(8'h55, 1'b1, 0);
      chk("b2b_done2",  64'(done),  64'd1);
      chk("b2b_short2", 64'(short), 64'd0);
      repeat (3) next_cycle();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
